// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: buffers writes from the execution units and drains
// them in order onto the single RF write port, with two youngest-value lookup ports.
`timescale 1ns/1ps
module rf_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wb_valid,
  output logic                       o_wb_ready,
  input  logic [4:0]                 i_wb_addr,
  input  logic [31:0]                i_wb_data,
  input  logic                       i_drain_en,
  output logic                       o_rd_wen,
  output logic [4:0]                 o_rd_waddr,
  output logic [31:0]                o_rd_wdata,
  input  logic [4:0]                 i_rs1_raddr,
  output logic                       o_rs1_hit,
  output logic [31:0]                o_rs1_data,
  input  logic [4:0]                 i_rs2_raddr,
  output logic                       o_rs2_hit,
  output logic [31:0]                o_rs2_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] ent_cnt;
  logic [CNT_W-1:0] ent_cnt_nxt;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic             full;
  logic             ready;
  logic             accept;
  logic             store;
  logic             deq;
  logic [PTR_W-1:0] age_idx [DEPTH];

  assign full    = (ent_cnt == CNT_W'(DEPTH));
  // Gated by reset so the producer sees "not ready" for the whole reset window.
  assign ready   = i_rst_n && !full;
  assign accept  = i_wb_valid && ready;
  assign store   = accept && (i_wb_addr != 5'd0);
  assign deq     = i_drain_en && (ent_cnt != '0);

  assign o_wb_ready = ready;
  assign o_rd_wen   = deq;
  assign o_rd_waddr = ent_addr[head_ptr];
  assign o_rd_wdata = ent_data[head_ptr];
  assign o_count    = ent_cnt;
  assign o_empty    = (ent_cnt == '0);

  always_comb begin
    ent_cnt_nxt = ent_cnt;
    case ({store, deq})
      2'b10:   ent_cnt_nxt = ent_cnt + CNT_W'(1);
      2'b01:   ent_cnt_nxt = ent_cnt - CNT_W'(1);
      default: ent_cnt_nxt = ent_cnt;
    endcase
  end

  // Control state: pointers, occupancy and per-entry valid bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      ent_cnt  <= '0;
      ent_vld  <= '0;
    end else begin
      if (store) begin
        ent_vld[tail_ptr] <= 1'b1;
        tail_ptr          <= tail_ptr + PTR_W'(1);
      end
      if (deq) begin
        ent_vld[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + PTR_W'(1);
      end
      ent_cnt <= ent_cnt_nxt;
    end
  end

  // Entry payload storage
  always_ff @(posedge i_clk) begin
    if (store) begin
      ent_addr[tail_ptr] <= i_wb_addr;
      ent_data[tail_ptr] <= i_wb_data;
    end
  end

  // Slots listed oldest-first starting at the head, so the last match is the youngest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign age_idx[g] = head_ptr + PTR_W'(g);
  end

  always_comb begin
    o_rs1_hit  = 1'b0;
    o_rs1_data = '0;
    o_rs2_hit  = 1'b0;
    o_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[age_idx[i]] && (ent_addr[age_idx[i]] == i_rs1_raddr) && (i_rs1_raddr != 5'd0)) begin
        o_rs1_hit  = 1'b1;
        o_rs1_data = ent_data[age_idx[i]];
      end
      if (ent_vld[age_idx[i]] && (ent_addr[age_idx[i]] == i_rs2_raddr) && (i_rs2_raddr != 5'd0)) begin
        o_rs2_hit  = 1'b1;
        o_rs2_data = ent_data[age_idx[i]];
      end
    end
  end

endmodule
